// File: rtl/hpdcache_req_rr_arbiter_if.sv
// Bundle of request and response signals between the requesters, the
// arbiter and the cache request port.
interface hpdcache_req_rr_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned REQ_W = 128,
  parameter int unsigned RSP_W = 96,
  parameter int unsigned SID_W = 3
);
  logic [N_REQ-1:0]       req_valid_i;
  logic [N_REQ-1:0]       req_ready_o;
  logic [N_REQ*REQ_W-1:0] req_i;
  logic [N_REQ-1:0]       req_lock_i;
  logic                   req_valid_o;
  logic                   req_ready_i;
  logic [REQ_W-1:0]       req_o;
  logic [SID_W-1:0]       req_sid_o;
  logic                   rsp_valid_i;
  logic [SID_W-1:0]       rsp_sid_i;
  logic [RSP_W-1:0]       rsp_i;
  logic [N_REQ-1:0]       rsp_valid_o;
  logic [RSP_W-1:0]       rsp_o;
  logic                   rsp_sid_err_o;
  logic [N_REQ-1:0]       starve_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_i, req_lock_i, req_ready_i,
    input  rsp_valid_i, rsp_sid_i, rsp_i,
    output req_ready_o, req_valid_o, req_o, req_sid_o,
    output rsp_valid_o, rsp_o, rsp_sid_err_o, starve_o
  );

  // Requester / cache side.
  modport master (
    output req_valid_i, req_i, req_lock_i, req_ready_i,
    output rsp_valid_i, rsp_sid_i, rsp_i,
    input  req_ready_o, req_valid_o, req_o, req_sid_o,
    input  rsp_valid_o, rsp_o, rsp_sid_err_o, starve_o
  );
endinterface

// File: rtl/hpdcache_req_rr_arbiter.sv
// N-requester round-robin front-end for the HPDcache request port, with
// grant locking, per-channel starvation flags and response demux by SID.
module hpdcache_req_rr_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned REQ_W    = 128,
  parameter int unsigned RSP_W    = 96,
  parameter int unsigned SID_W    = 3,
  parameter int unsigned STARVE_W = 4
) (
  input logic clk_i,
  input logic rst_ni,
  hpdcache_req_rr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [STARVE_W-1:0] CNT_MAX = '1;
  localparam logic [SID_W:0] N_REQ_SID = (SID_W+1)'(N_REQ);

  logic                 req_valid_q;
  logic [REQ_W-1:0]     req_q;
  logic [IDX_W-1:0]     sid_q;
  logic [IDX_W-1:0]     ptr_q;
  logic                 lock_q;
  logic [IDX_W-1:0]     lock_id_q;
  logic [STARVE_W-1:0]  cnt_q [N_REQ];
  logic [N_REQ-1:0]     starve_q;

  logic                 slot_free;
  logic                 win_valid;
  logic [IDX_W-1:0]     winner;
  logic [IDX_W-1:0]     cand;
  logic [REQ_W-1:0]     win_pay;
  logic [N_REQ-1:0]     grant;
  logic                 handshake;

  assign slot_free = !req_valid_q || bus.req_ready_i;
  assign handshake = slot_free && win_valid;

  // Pick the winner: the locked channel, else first valid after ptr.
  always_comb begin
    win_valid = 1'b0;
    winner    = ptr_q;
    cand      = '0;
    if (lock_q) begin
      winner    = lock_id_q;
      win_valid = bus.req_valid_i[lock_id_q];
    end else begin
      for (int unsigned i = 1; i <= N_REQ; i++) begin
        cand = IDX_W'((32'(ptr_q) + i) % N_REQ);
        if (!win_valid && bus.req_valid_i[cand]) begin
          win_valid = 1'b1;
          winner    = cand;
        end
      end
    end
  end

  // Ready fan-out and winner payload select.
  always_comb begin
    grant   = '0;
    win_pay = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (winner == IDX_W'(k)) begin
        win_pay  = bus.req_i[k*REQ_W +: REQ_W];
        grant[k] = handshake;
      end
    end
  end

  // Output slot: load the winner when free, drain when the cache takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
      sid_q       <= '0;
    end else if (handshake) begin
      req_valid_q <= 1'b1;
      req_q       <= win_pay;
      sid_q       <= winner;
    end else if (bus.req_ready_i) begin
      req_valid_q <= 1'b0;
    end
  end

  // Pointer and lock follow every accepted request; while locked the
  // winner is the lock owner, so the pointer stays put.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= IDX_W'(N_REQ - 1);
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (handshake) begin
      ptr_q     <= winner;
      lock_q    <= bus.req_lock_i[winner];
      lock_id_q <= winner;
    end
  end

  // Per-channel wait counters with a sticky saturation flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < N_REQ; k++) cnt_q[k] <= '0;
      starve_q <= '0;
    end else begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (grant[k]) begin
          cnt_q[k] <= '0;
        end else if (bus.req_valid_i[k] && (cnt_q[k] != CNT_MAX)) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
          if (cnt_q[k] == CNT_MAX - 1'b1) starve_q[k] <= 1'b1;
        end
      end
    end
  end

  // Response demux; out-of-range SIDs are dropped and flagged.
  always_comb begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      bus.rsp_valid_o[k] = bus.rsp_valid_i && ({1'b0, bus.rsp_sid_i} == (SID_W+1)'(k));
    end
  end

  assign bus.rsp_sid_err_o = bus.rsp_valid_i && ({1'b0, bus.rsp_sid_i} >= N_REQ_SID);
  assign bus.rsp_o         = bus.rsp_i;
  assign bus.req_ready_o   = grant;
  assign bus.req_valid_o   = req_valid_q;
  assign bus.req_o         = req_q;
  assign bus.req_sid_o     = SID_W'(sid_q);
  assign bus.starve_o      = starve_q;
endmodule
